interrupt_dispatcher: RTL and testbench

Consumer end of the watchdog's interruption interface. Latches the two-bit interruption code, waits for an instruction boundary, saves the interrupted PC, and redirects the control unit to the cause's vector in kernel mode. Holds kernel mode until the handler returns. Its `kernel_mode` output drives the watchdog's `is_kernel` input, which closes the loop. Sits in the ControlUnit between the Watchdog and the PC/fetch logic.

---
 rtl/control_unit_pkg.sv | 19 +
 rtl/sat_counter.sv | 16 +
 rtl/interrupt_dispatcher.sv | 106 ++++++++++
 tb/tb_interrupt_dispatcher.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared control-unit definitions: dispatcher state encoding, interruption
// codes (also used by the watchdog) and default handler vectors.
package control_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    DISPATCH = 2'd2,
    HANDLER  = 2'd3
  } state_t;

  localparam logic [1:0] INT_NONE  = 2'd0;
  localparam logic [1:0] INT_USER  = 2'd1;
  localparam logic [1:0] INT_TIMER = 2'd2;

  localparam logic [15:0] DEF_USER_VECTOR  = 16'h0010;
  localparam logic [15:0] DEF_TIMER_VECTOR = 16'h0020;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 count <= '0;
    else if (en && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/interrupt_dispatcher.sv
// Latches watchdog interruption codes, dispatches at an instruction boundary
// and holds kernel mode until return. INTERRUPT_STATS_EN adds dispatch counters.
module interrupt_dispatcher
  import control_unit_pkg::*;
#(
  parameter int                       INTERRUPTION_SIZE = 2,
  parameter int                       ADDRESS_SIZE      = 16,
  parameter logic [ADDRESS_SIZE-1:0]  USER_VECTOR       = ADDRESS_SIZE'(DEF_USER_VECTOR),
  parameter logic [ADDRESS_SIZE-1:0]  TIMER_VECTOR      = ADDRESS_SIZE'(DEF_TIMER_VECTOR)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [INTERRUPTION_SIZE-1:0] interruption,
  input  logic                         is_Bios,
  input  logic                         instruction_done,
  input  logic [ADDRESS_SIZE-1:0]      current_pc,
  input  logic                         return_from_interrupt,
  output logic                         take_interrupt,
  output logic [ADDRESS_SIZE-1:0]      vector_address,
  output logic                         resume,
  output logic [ADDRESS_SIZE-1:0]      saved_pc,
  output logic [INTERRUPTION_SIZE-1:0] cause,
`ifdef INTERRUPT_STATS_EN
  output logic [7:0]                   user_count,
  output logic [7:0]                   timer_count,
`endif
  output logic                         kernel_mode
);

  localparam logic [INTERRUPTION_SIZE-1:0] C_USER  = INTERRUPTION_SIZE'(INT_USER);
  localparam logic [INTERRUPTION_SIZE-1:0] C_TIMER = INTERRUPTION_SIZE'(INT_TIMER);

  state_t                       state;
  logic                         req, user_req, go;
  logic [INTERRUPTION_SIZE-1:0] cause_nxt;

  // Any nonzero code other than timer counts as a user request.
  always_comb begin
    req       = interruption != '0;
    user_req  = req && (interruption != C_TIMER);
    cause_nxt = cause;
    go        = 1'b0;
    case (state)
      IDLE:    if (req && !is_Bios) cause_nxt = user_req ? C_USER : C_TIMER;
      PENDING: begin
        if (user_req) cause_nxt = C_USER;
        go = instruction_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      take_interrupt <= 1'b0;
      vector_address <= '0;
      resume         <= 1'b0;
      saved_pc       <= '0;
      cause          <= '0;
      kernel_mode    <= 1'b0;
    end else begin
      take_interrupt <= 1'b0;
      resume         <= 1'b0;
      vector_address <= '0;
      cause          <= cause_nxt;
      case (state)
        IDLE: begin
          // kernel_mode stays up through the resume cycle and drops here.
          kernel_mode <= 1'b0;
          if (req && !is_Bios) state <= PENDING;
        end
        PENDING: if (go) begin
          state          <= DISPATCH;
          saved_pc       <= current_pc;
          take_interrupt <= 1'b1;
          kernel_mode    <= 1'b1;
          vector_address <= (cause_nxt == C_USER) ? USER_VECTOR : TIMER_VECTOR;
        end
        DISPATCH: state <= HANDLER;
        HANDLER: if (return_from_interrupt) begin
          state  <= IDLE;
          resume <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INTERRUPT_STATS_EN
  sat_counter #(.WIDTH(8)) u_user_cnt (
    .clock (clock),
    .reset (reset),
    .en    (go && cause_nxt == C_USER),
    .count (user_count)
  );

  sat_counter #(.WIDTH(8)) u_timer_cnt (
    .clock (clock),
    .reset (reset),
    .en    (go && cause_nxt == C_TIMER),
    .count (timer_count)
  );
`endif

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Directed + random bench for interrupt_dispatcher against a transaction-level
// model of pending request, handler occupancy and the dispatch/resume pulses.
module tb_interrupt_dispatcher;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  interruption = '0;
  logic        is_Bios = 1'b0;
  logic        instruction_done = 1'b0;
  logic [15:0] current_pc = '0;
  logic        return_from_interrupt = 1'b0;
  logic        take_interrupt, resume, kernel_mode;
  logic [15:0] vector_address, saved_pc;
  logic [1:0]  cause;
`ifdef INTERRUPT_STATS_EN
  logic [7:0]  user_count, timer_count;
`endif

  interrupt_dispatcher dut (
    .clock                 (clock),
    .reset                 (reset),
    .interruption          (interruption),
    .is_Bios               (is_Bios),
    .instruction_done      (instruction_done),
    .current_pc            (current_pc),
    .return_from_interrupt (return_from_interrupt),
    .take_interrupt        (take_interrupt),
    .vector_address        (vector_address),
    .resume                (resume),
    .saved_pc              (saved_pc),
    .cause                 (cause),
`ifdef INTERRUPT_STATS_EN
    .user_count            (user_count),
    .timer_count           (timer_count),
`endif
    .kernel_mode           (kernel_mode)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a request is either waiting for a boundary, being
  // served by a handler, or absent; pulses are tracked as flags.
  bit          m_pend, m_hand, m_take, m_res;
  logic [1:0]  m_cause;
  logic [15:0] m_saved;
  int          m_ucnt, m_tcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_hand = 0; m_take = 0; m_res = 0;
    m_cause = 0; m_saved = 0; m_ucnt = 0; m_tcnt = 0;
  endtask

  task automatic model_step();
    bit nt, nr;
    nt = 0; nr = 0;
    if (m_take) m_hand = 1;
    else if (m_hand) begin
      if (return_from_interrupt) begin m_hand = 0; nr = 1; end
    end else if (m_pend) begin
      if (interruption == 1 || interruption == 3) m_cause = 1;
      if (instruction_done) begin
        m_saved = current_pc; nt = 1; m_pend = 0;
        if (m_cause == 1) m_ucnt = (m_ucnt < 255) ? m_ucnt + 1 : 255;
        else              m_tcnt = (m_tcnt < 255) ? m_tcnt + 1 : 255;
      end
    end else if (interruption != 0 && !is_Bios) begin
      m_pend = 1;
      m_cause = (interruption == 2) ? 2'd2 : 2'd1;
    end
    m_take = nt; m_res = nr;
  endtask

  task automatic check_outs();
    chk("take", take_interrupt, m_take);
    chk("resume", resume, m_res);
    chk("kernel", kernel_mode, m_take || m_hand || m_res);
    chk("vector", vector_address, m_take ? (m_cause == 1 ? 16'h0010 : 16'h0020) : 16'h0000);
    chk("saved_pc", saved_pc, m_saved);
    chk("cause", cause, m_cause);
`ifdef INTERRUPT_STATS_EN
    chk("user_count", user_count, m_ucnt);
    chk("timer_count", timer_count, m_tcnt);
`endif
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1 check_outs();
    @(negedge clock);
  endtask

  task automatic quiet();
    interruption = 0; is_Bios = 0; instruction_done = 0; return_from_interrupt = 0;
  endtask

  initial begin
    model_reset();
    #1 check_outs();
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    // Timer request one cycle, boundary three cycles later.
    interruption = 2; cycle();
    interruption = 0; cycle(); cycle();
    instruction_done = 1; current_pc = 16'h0123; cycle();
    chk("t2_take", take_interrupt, 1);
    chk("t2_vec", vector_address, 16'h0020);
    chk("t2_pc", saved_pc, 16'h0123);
    chk("t2_kern", kernel_mode, 1);
    instruction_done = 0; cycle();

    // Codes in the handler are ignored; return pulses resume.
    interruption = 1;
    for (int i = 0; i < 5; i++) cycle();
    interruption = 0; return_from_interrupt = 1; cycle();
    chk("t4_resume", resume, 1);
    chk("t4_pc", saved_pc, 16'h0123);
    return_from_interrupt = 0; cycle();
    chk("t4_kern_off", kernel_mode, 0);

    // Timer pending upgraded by user code; then code 3.
    interruption = 2; cycle();
    interruption = 1; cycle();
    interruption = 0; instruction_done = 1; current_pc = 16'h0456; cycle();
    chk("t3_vec", vector_address, 16'h0010);
    chk("t3_cause", cause, 1);
    quiet(); cycle();
    return_from_interrupt = 1; cycle();
    quiet(); cycle();
    interruption = 3; cycle();
    interruption = 0; instruction_done = 1; cycle();
    chk("t3_code3", cause, 1);
    quiet(); cycle();

    // Return and timer code together: resume first, then a new dispatch.
    return_from_interrupt = 1; interruption = 2; cycle();
    chk("t5_resume", resume, 1);
    return_from_interrupt = 0; cycle();
    chk("t5_no_take", take_interrupt, 0);
    interruption = 0; instruction_done = 1; current_pc = 16'h0789; cycle();
    chk("t5_take", take_interrupt, 1);
    chk("t5_vec", vector_address, 16'h0020);
    quiet(); cycle();
    cycle();

    // Async reset in HANDLER with cause 2.
    chk("t1_cause_pre", cause, 2);
    #2 reset = 1'b0;
    #1 model_reset(); check_outs();
    chk("t1_kern", kernel_mode, 0);
    @(negedge clock); reset = 1'b1;
    cycle(); cycle();
    chk("t1_no_resume", resume, 0);

    // BIOS blocks new requests.
    is_Bios = 1; interruption = 2; cycle(); cycle();
    instruction_done = 1; cycle(); cycle();
    chk("bios_take", take_interrupt, 0);
    quiet(); cycle();

    // 260 timer dispatches from a clean reset.
    reset = 1'b0; #1 model_reset();
    @(negedge clock); reset = 1'b1;
    for (int i = 0; i < 260; i++) begin
      interruption = 2; cycle();
      interruption = 0; instruction_done = 1; current_pc = 16'($urandom); cycle();
      instruction_done = 0; cycle();
      return_from_interrupt = 1; cycle();
      return_from_interrupt = 0; cycle();
    end
`ifdef INTERRUPT_STATS_EN
    chk("stat_timer", timer_count, 255);
    chk("stat_user", user_count, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      interruption          = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'd0;
      instruction_done      = ($urandom_range(0, 2) == 0);
      return_from_interrupt = ($urandom_range(0, 3) == 0);
      is_Bios               = ($urandom_range(0, 7) == 0);
      current_pc            = 16'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
